// File: rtl/ev22_fetch_unit.sv
// ev22_fetch_unit: EV22 fetch stage owning PC, instruction register and return-address stack.
// Define EV22_FETCH_STACK_GUARD_EN to halt on stack overflow/underflow instead of wrapping.
module ev22_fetch_unit #(
  parameter int                 ADDR_W      = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
  parameter int                 STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_req,
  input  logic              imem_ack,
  input  logic [23:0]       imem_data,
  output logic [7:0]        opcode,
  output logic [4:0]        ri,
  output logic [4:0]        rj,
  output logic [15:0]       k,
  output logic              instr_valid,
  input  logic              issue_ack,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              stk_ovf,
  output logic              stk_unf
);
  localparam int IW = $clog2(STACK_DEPTH);
  localparam int SP_W = IW + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
`ifdef EV22_FETCH_STACK_GUARD_EN
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
`endif
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, bsr_tgt;
  logic [23:0] ir_q, ir_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
  logic [ADDR_W-1:0] stk_d [STACK_DEPTH];
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic is_bsr, is_ret;
  logic [IW-1:0] top_idx;
  assign imem_req = state_q == FETCH;
  assign instr_valid = state_q == ISSUE;
  assign imem_addr = pc_q;
  assign pc = pc_q;
  assign opcode = ir_q[23:16];
  assign ri = ir_q[9:5];
  assign rj = ir_q[4:0];
  assign k = ir_q[15:0];
  assign stk_ovf = ovf_q;
  assign stk_unf = unf_q;
  assign is_bsr = ir_q[23:18] == 6'b000111;
  assign is_ret = ir_q[23:16] == 8'h41;
  assign pc_inc = pc_q + 1'b1;
  assign bsr_tgt = pc_inc + ADDR_W'(ir_q[17:16]);
  assign top_idx = IW'(sp_q - 1'b1);
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    sp_d = sp_q;
    stk_d = stk_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: if (imem_ack) begin
        ir_d = imem_data;
        state_d = ISSUE;
      end
      ISSUE: if (issue_ack) begin
        state_d = FETCH;
        if (redir_valid) pc_d = redir_addr;
        else if (is_bsr) begin
          pc_d = bsr_tgt;
          if (sp_q == SP_FULL) begin
            ovf_d = 1'b1;
`ifdef EV22_FETCH_STACK_GUARD_EN
            pc_d = pc_q;
            state_d = HALT;
`else
            // full stack: shift out the oldest return address, newest lands on top
            for (int i = 0; i < STACK_DEPTH - 1; i++) stk_d[i] = stk_q[i+1];
            stk_d[STACK_DEPTH-1] = pc_inc;
`endif
          end else begin
            stk_d[sp_q[IW-1:0]] = pc_inc;
            sp_d = sp_q + 1'b1;
          end
        end else if (is_ret) begin
          if (sp_q == '0) begin
            unf_d = 1'b1;
            pc_d = pc_inc;
`ifdef EV22_FETCH_STACK_GUARD_EN
            pc_d = pc_q;
            state_d = HALT;
`endif
          end else begin
            pc_d = stk_q[top_idx];
            sp_d = sp_q - 1'b1;
          end
        end else pc_d = pc_inc;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      ir_q <= '0;
      sp_q <= '0;
      stk_q <= '{default: '0};
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      sp_q <= sp_d;
      stk_q <= stk_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
endmodule

// File: tb/tb_ev22_fetch_unit.sv
// tb_ev22_fetch_unit: directed scenario bench for ev22_fetch_unit (ADDR_W=8, STACK_DEPTH=4).
module tb_ev22_fetch_unit;
  logic clk = 0, rst = 1;
  logic [7:0] imem_addr;
  logic imem_req, imem_ack = 0;
  logic [23:0] imem_data = '0;
  logic [7:0] opcode;
  logic [4:0] ri, rj;
  logic [15:0] k;
  logic instr_valid, issue_ack = 0, redir_valid = 0;
  logic [7:0] redir_addr = '0;
  logic [7:0] pc;
  logic stk_ovf, stk_unf;
  int pass_cnt = 0, total = 0;

  ev22_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_ack(imem_ack), .imem_data(imem_data), .opcode(opcode), .ri(ri),
    .rj(rj), .k(k), .instr_valid(instr_valid), .issue_ack(issue_ack),
    .redir_valid(redir_valid), .redir_addr(redir_addr), .pc(pc),
    .stk_ovf(stk_ovf), .stk_unf(stk_unf));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; imem_ack = 0; issue_ack = 0; redir_valid = 0;
    cyc();
    rst = 0;
  endtask

  // waits (bounded) for a request, acks one cycle later; a = 'x on timeout
  task automatic do_fetch(input logic [23:0] w, output logic [7:0] a);
    int n = 0;
    a = 'x;
    while (!imem_req && n < 10) begin cyc(); n++; end
    if (imem_req) begin
      a = imem_addr;
      cyc();
      imem_ack = 1; imem_data = w;
      cyc();
      imem_ack = 0;
    end
  endtask

  task automatic do_issue(input logic rv, input logic [7:0] ra);
    issue_ack = 1; redir_valid = rv; redir_addr = ra;
    cyc();
    issue_ack = 0; redir_valid = 0;
  endtask

  task automatic run(input logic [23:0] w, input logic rv, input logic [7:0] ra, output logic [7:0] a);
    do_fetch(w, a);
    do_issue(rv, ra);
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    total++; if ({imem_req, instr_valid} !== 2'b00) $display("FAIL reset_ctl got %b want 00", {imem_req, instr_valid}); else pass_cnt++;
    total++; if (pc !== 8'h00) $display("FAIL reset_pc got %0h want 0", pc); else pass_cnt++;
    total++; if ({opcode, k} !== 24'h0) $display("FAIL reset_ir got %0h want 0", {opcode, k}); else pass_cnt++;
    total++; if ({stk_ovf, stk_unf} !== 2'b00) $display("FAIL reset_flags got %b want 00", {stk_ovf, stk_unf}); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_sequential();
    logic [7:0] a;
    do_reset();
    do_fetch(24'h0A0000, a);
    total++; if (a !== 8'h00) $display("FAIL seq_addr0 got %0h want 0", a); else pass_cnt++;
    total++; if (opcode !== 8'h0A || instr_valid !== 1'b1) $display("FAIL seq_op0 got %0h/%b want 0a/1", opcode, instr_valid); else pass_cnt++;
    do_issue(0, 0);
    total++; if (instr_valid !== 1'b0) $display("FAIL seq_valid_drop got %b want 0", instr_valid); else pass_cnt++;
    do_fetch(24'h0B03A5, a);
    total++; if (a !== 8'h01) $display("FAIL seq_addr1 got %0h want 1", a); else pass_cnt++;
    total++; if ({opcode, ri, rj, k} !== {8'h0B, 5'h1D, 5'h05, 16'h03A5}) $display("FAIL seq_fields got %0h %0h %0h %0h want b 1d 5 3a5", opcode, ri, rj, k); else pass_cnt++;
    do_issue(0, 0);
    do_fetch(24'h000000, a);
    total++; if (a !== 8'h02) $display("FAIL seq_addr2 got %0h want 2", a); else pass_cnt++;
    do_issue(0, 0);
  endtask

  task automatic test_bsr_ret();
    logic [7:0] a;
    do_reset();
    run(24'h000000, 1, 8'h05, a);
    do_fetch(24'h1C0000, a);
    total++; if (a !== 8'h05) $display("FAIL bsr_addr got %0h want 5", a); else pass_cnt++;
    do_issue(0, 0);
    total++; if (pc !== 8'h06) $display("FAIL bsr0_pc got %0h want 6", pc); else pass_cnt++;
    run(24'h1E0000, 0, 0, a);
    total++; if (pc !== 8'h09) $display("FAIL bsr2_pc got %0h want 9", pc); else pass_cnt++;
    total++; if (dut.sp_q !== 3'd2) $display("FAIL bsr_sp got %0d want 2", dut.sp_q); else pass_cnt++;
    run(24'h410000, 0, 0, a);
    total++; if (pc !== 8'h07) $display("FAIL ret1_pc got %0h want 7", pc); else pass_cnt++;
    run(24'h410000, 0, 0, a);
    total++; if (pc !== 8'h06 || dut.sp_q !== 3'd0) $display("FAIL ret2 got pc %0h sp %0d want 6/0", pc, dut.sp_q); else pass_cnt++;
  endtask

  task automatic test_redirect();
    logic [7:0] a;
    do_reset();
    run(24'h000000, 1, 8'h03, a);
    do_fetch(24'h1C0000, a);
    do_issue(1, 8'h40);
    total++; if (pc !== 8'h40 || dut.sp_q !== 3'd0) $display("FAIL redir got pc %0h sp %0d want 40/0", pc, dut.sp_q); else pass_cnt++;
    do_fetch(24'h000000, a);
    total++; if (a !== 8'h40) $display("FAIL redir_fetch got %0h want 40", a); else pass_cnt++;
    do_issue(0, 0);
  endtask

  task automatic test_overflow();
    logic [7:0] a;
    logic [7:0] exp_ret [4] = '{8'h05, 8'h04, 8'h03, 8'h02};
    do_reset();
    for (int i = 0; i < 5; i++) run(24'h1C0000, 0, 0, a);
    total++; if (stk_ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", stk_ovf); else pass_cnt++;
`ifdef EV22_FETCH_STACK_GUARD_EN
    total++; if (pc !== 8'h04) $display("FAIL ovf_halt_pc got %0h want 4", pc); else pass_cnt++;
    for (int i = 0; i < 4; i++) cyc();
    total++; if ({imem_req, instr_valid} !== 2'b00) $display("FAIL ovf_halt got %b want 00", {imem_req, instr_valid}); else pass_cnt++;
`else
    total++; if (pc !== 8'h05) $display("FAIL ovf_pc got %0h want 5", pc); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      run(24'h410000, 0, 0, a);
      total++; if (pc !== exp_ret[i]) $display("FAIL ovf_ret%0d got %0h want %0h", i, pc, exp_ret[i]); else pass_cnt++;
    end
    total++; if (stk_unf !== 1'b0) $display("FAIL ovf_no_unf got %b want 0", stk_unf); else pass_cnt++;
`endif
  endtask

  task automatic test_underflow();
    logic [7:0] a;
    do_reset();
    run(24'h000000, 1, 8'hFF, a);
    run(24'h410000, 0, 0, a);
    total++; if (stk_unf !== 1'b1) $display("FAIL unf_flag got %b want 1", stk_unf); else pass_cnt++;
`ifdef EV22_FETCH_STACK_GUARD_EN
    cyc();
    total++; if (pc !== 8'hFF || imem_req !== 1'b0) $display("FAIL unf_halt got pc %0h req %b want ff/0", pc, imem_req); else pass_cnt++;
`else
    total++; if (pc !== 8'h00 || dut.sp_q !== 3'd0) $display("FAIL unf_pc got pc %0h sp %0d want 0/0", pc, dut.sp_q); else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_fetch();
    logic [7:0] a;
    do_reset();
    run(24'h000000, 1, 8'h20, a);
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h20) $display("FAIL mid_pre got req %b addr %0h want 1/20", imem_req, imem_addr); else pass_cnt++;
    rst = 1;
    #1;
    total++; if (imem_req !== 1'b0 || pc !== 8'h00) $display("FAIL mid_async got req %b pc %0h want 0/0", imem_req, pc); else pass_cnt++;
    cyc();
    rst = 0; imem_ack = 1; imem_data = 24'h550000;
    cyc();
    imem_ack = 0;
    total++; if (instr_valid !== 1'b0 || opcode !== 8'h00) $display("FAIL late_ack got valid %b op %0h want 0/0", instr_valid, opcode); else pass_cnt++;
    do_fetch(24'h0C0000, a);
    total++; if (a !== 8'h00 || opcode !== 8'h0C) $display("FAIL mid_refetch got addr %0h op %0h want 0/c", a, opcode); else pass_cnt++;
    do_issue(0, 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    cyc();
    imem_ack = 1; imem_data = 24'h0D0000;
    cyc();
    total++; if (instr_valid !== 1'b1 || opcode !== 8'h0D) $display("FAIL b2b_valid got %b op %0h want 1/d", instr_valid, opcode); else pass_cnt++;
    imem_data = 24'h0E0000; issue_ack = 1;
    cyc();
    issue_ack = 0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 8'h01 || opcode !== 8'h0D) $display("FAIL b2b_next got req %b addr %0h op %0h want 1/1/d", imem_req, imem_addr, opcode); else pass_cnt++;
    cyc();
    imem_ack = 0;
    total++; if (instr_valid !== 1'b1 || opcode !== 8'h0E) $display("FAIL b2b_second got %b op %0h want 1/e", instr_valid, opcode); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_bsr_ret();
    test_redirect();
    test_overflow();
    test_underflow();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
